// File: rtl/axi_4_slave_burst_datapath_pkg.sv
// rtl/axi_4_slave_burst_datapath_pkg.sv - shared burst types, responses and FSM states
package axi_4_slave_burst_datapath_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_4_burst_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        DP_IDLE,
        DP_RD_REQ,
        DP_RD_HOLD,
        DP_WR_ARM,
        DP_WR_REQ,
        DP_WR_HOLD
    } axi_4_dp_states_e;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats
    function automatic logic wrap_len_bad(input logic [1:0] burst, input logic [7:0] len);
        return (burst == BURST_WRAP) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_4_slave_burst_datapath_addr_gen.sv
// rtl/axi_4_slave_burst_datapath_addr_gen.sv - combinational next beat address for FIXED/INCR/WRAP
module axi_4_slave_burst_datapath_addr_gen
    import axi_4_slave_burst_datapath_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              wrap_err
);

    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;

    always_comb begin
        bytes     = ADDR_W'(1) << size;
        incr      = addr + bytes;
        mask      = ((ADDR_W'(len) + ADDR_W'(1)) * bytes) - ADDR_W'(1);
        wrap_err  = wrap_len_bad(burst, len);
        next_addr = incr;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if (burst == BURST_WRAP && !wrap_err) begin
            next_addr = (addr & ~mask) | (incr & mask);
        end
    end

endmodule

// File: rtl/axi_4_slave_burst_datapath.sv
// rtl/axi_4_slave_burst_datapath.sv - AXI4 slave burst datapath: beat addressing and memory handshake
module axi_4_slave_burst_datapath
    import axi_4_slave_burst_datapath_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m_arvalid,
    input  logic                s_arready,
    input  logic [ADDR_W-1:0]   m_araddr,
    input  logic [7:0]          m_arlen,
    input  logic [2:0]          m_arsize,
    input  logic [1:0]          m_arburst,
    input  logic                m_awvalid,
    input  logic                s_awready,
    input  logic [ADDR_W-1:0]   m_awaddr,
    input  logic [7:0]          m_awlen,
    input  logic [2:0]          m_awsize,
    input  logic [1:0]          m_awburst,
    input  logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_wlast,
    input  logic                m_rready,
    input  logic                m_bready,
    input  logic                incre_counter,
    input  logic                store_data,
    output logic                data_fetched,
    output logic                s_rlast,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                data_stored,
    output logic                wlast_done,
    output logic [1:0]          s_bresp,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int SIZE_MAX = $clog2(STRB_W);

    axi_4_dp_states_e  state, next_state;
    logic [ADDR_W-1:0] addr_q, next_addr;
    logic [7:0]        len_q, beat_cnt;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              err_q, wrap_err, oor, beat_err, last_beat, ar_hs, aw_hs;

    assign ar_hs     = m_arvalid & s_arready;
    assign aw_hs     = m_awvalid & s_awready;
    assign oor       = addr_q >= ADDR_W'(MEM_BYTES);
    assign beat_err  = err_q | wrap_err | oor;
    assign last_beat = (beat_cnt == len_q);

    axi_4_slave_burst_datapath_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr),
        .wrap_err  (wrap_err)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= DP_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            DP_IDLE:    if (ar_hs) next_state = DP_RD_REQ;
                        else if (aw_hs) next_state = DP_WR_ARM;
            DP_RD_REQ:  if (oor || mem_ack) next_state = DP_RD_HOLD;
            DP_RD_HOLD: if (incre_counter && !s_rlast) next_state = DP_RD_REQ;
                        else if (s_rlast && m_rready) next_state = DP_IDLE;
            DP_WR_ARM:  if (store_data) next_state = DP_WR_REQ;
            DP_WR_REQ:  if (oor || mem_ack) next_state = DP_WR_HOLD;
            DP_WR_HOLD: if (incre_counter && !wlast_done) next_state = DP_WR_ARM;
                        else if (wlast_done && m_bready) next_state = DP_IDLE;
            default:    next_state = DP_IDLE;
        endcase
    end

    // Out-of-range beats never reach memory; they complete locally with SLVERR
    always_comb begin
        mem_req  = !oor && (state == DP_RD_REQ || state == DP_WR_REQ);
        mem_we   = !oor && (state == DP_WR_REQ);
        mem_addr = mem_req ? (addr_q & ~ADDR_W'(STRB_W - 1)) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            beat_cnt     <= '0;
            err_q        <= 1'b0;
            data_fetched <= 1'b0;
            s_rlast      <= 1'b0;
            s_rdata      <= '0;
            s_rresp      <= AXI_RESP_OKAY;
            data_stored  <= 1'b0;
            wlast_done   <= 1'b0;
            s_bresp      <= AXI_RESP_OKAY;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
        end else begin
            case (state)
                DP_IDLE: begin
                    if (ar_hs) begin
                        addr_q   <= m_araddr;
                        len_q    <= m_arlen;
                        size_q   <= m_arsize;
                        burst_q  <= m_arburst;
                        beat_cnt <= '0;
                        err_q    <= m_arsize > 3'(SIZE_MAX);
                    end else if (aw_hs) begin
                        addr_q   <= m_awaddr;
                        len_q    <= m_awlen;
                        size_q   <= m_awsize;
                        burst_q  <= m_awburst;
                        beat_cnt <= '0;
                        err_q    <= m_awsize > 3'(SIZE_MAX);
                        s_bresp  <= AXI_RESP_OKAY;
                    end
                end
                DP_RD_REQ: begin
                    if (oor || mem_ack) begin
                        data_fetched <= 1'b1;
                        s_rlast      <= last_beat;
                        s_rdata      <= oor ? '0 : mem_rdata;
                        s_rresp      <= beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        err_q        <= beat_err;
                    end
                end
                DP_RD_HOLD: begin
                    if (incre_counter && !s_rlast) begin
                        data_fetched <= 1'b0;
                        addr_q       <= next_addr;
                        beat_cnt     <= beat_cnt + 8'd1;
                    end else if (s_rlast && m_rready) begin
                        data_fetched <= 1'b0;
                        s_rlast      <= 1'b0;
                    end
                end
                DP_WR_ARM: begin
                    if (store_data) begin
                        mem_wdata <= m_wdata;
                        mem_wstrb <= m_wstrb;
                        if (m_wlast != last_beat) err_q <= 1'b1;
                    end
                end
                DP_WR_REQ: begin
                    if (oor || mem_ack) begin
                        data_stored <= 1'b1;
                        wlast_done  <= last_beat;
                        s_bresp     <= beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        err_q       <= beat_err;
                    end
                end
                DP_WR_HOLD: begin
                    if (incre_counter && !wlast_done) begin
                        data_stored <= 1'b0;
                        addr_q      <= next_addr;
                        beat_cnt    <= beat_cnt + 8'd1;
                    end else if (wlast_done && m_bready) begin
                        data_stored <= 1'b0;
                        wlast_done  <= 1'b0;
                        s_bresp     <= AXI_RESP_OKAY;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_4_slave_burst_datapath.sv
// tb/tb_axi_4_slave_burst_datapath.sv - directed and randomized bursts against a beat-list reference model
module tb_axi_4_slave_burst_datapath;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_arvalid, s_arready, m_awvalid, s_awready;
    logic [31:0] m_araddr, m_awaddr;
    logic [7:0]  m_arlen, m_awlen;
    logic [2:0]  m_arsize, m_awsize;
    logic [1:0]  m_arburst, m_awburst;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast, m_rready, m_bready, incre_counter, store_data;
    logic        data_fetched, s_rlast, data_stored, wlast_done;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack   = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] q_addr[$];
    logic        q_we[$];
    logic [31:0] q_wdata[$];
    logic [3:0]  q_wstrb[$];
    bit          resp_en = 1'b1;
    int          ack_max = 0;
    int          wait_cnt = 0;

    always #5 clk = ~clk;

    axi_4_slave_burst_datapath #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .reset(reset),
        .m_arvalid(m_arvalid), .s_arready(s_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_awvalid(m_awvalid), .s_awready(s_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_rready(m_rready),
        .m_bready(m_bready), .incre_counter(incre_counter), .store_data(store_data),
        .data_fetched(data_fetched), .s_rlast(s_rlast), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .data_stored(data_stored), .wlast_done(wlast_done), .s_bresp(s_bresp),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Memory responder: acks after 0..ack_max cycles and logs every request it serves
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end else if (resp_en && mem_req) begin
            if (wait_cnt > 0) begin
                wait_cnt--;
            end else begin
                q_addr.push_back(mem_addr);
                q_we.push_back(mem_we);
                q_wdata.push_back(mem_wdata);
                q_wstrb.push_back(mem_wstrb);
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else begin
                    mem_rdata = mem[mem_addr[11:2]];
                end
                mem_ack  = 1'b1;
                wait_cnt = int'($urandom_range(32'(ack_max), 0));
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference beat address: i-th beat of the burst, from the protocol's arithmetic definition
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len, input int size,
                                              input int burst, input int i);
        longint s     = longint'(start);
        longint bytes = longint'(1) << size;
        longint total = longint'(len + 1) * bytes;
        longint base;
        bit     wrap_ok = (burst == 2) && (len == 1 || len == 3 || len == 7 || len == 15);
        if (burst == 0) return start;
        if (wrap_ok) begin
            base = (s / total) * total;
            return 32'(base + ((s - base + longint'(i) * bytes) % total));
        end
        return 32'(s + longint'(i) * bytes);
    endfunction

    function automatic bit cfg_err(input int len, input int size, input int burst);
        return (size > 2) || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    task automatic clear_queues();
        q_addr.delete(); q_we.delete(); q_wdata.delete(); q_wstrb.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input int size, input int burst,
                           input int hold, input bit with_aw);
        logic [31:0] a, exp_data;
        bit err, oor;
        err = cfg_err(len, size, burst);
        m_araddr = addr; m_arlen = 8'(len); m_arsize = 3'(size); m_arburst = 2'(burst);
        m_arvalid = 1'b1; s_arready = 1'b1;
        if (with_aw) begin
            m_awaddr = addr + 32'h100; m_awlen = 8'd0; m_awsize = 3'd2; m_awburst = 2'd1;
            m_awvalid = 1'b1; s_awready = 1'b1;
        end
        @(negedge clk);
        m_arvalid = 1'b0; s_arready = 1'b0; m_awvalid = 1'b0; s_awready = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a   = beat_addr(addr, len, size, burst, i);
            oor = a >= 32'(MEM_BYTES);
            err = err | oor;
            for (int w = 0; w < 64 && !data_fetched; w++) @(negedge clk);
            check("rd_fetched", 64'(data_fetched), 64'(1));
            if (oor) begin
                check("rd_oor_noreq", 64'(q_addr.size()), 64'(0));
            end else begin
                check("rd_req_count", 64'(q_addr.size()), 64'(1));
                if (q_addr.size() > 0) begin
                    check("rd_mem_addr", 64'(q_addr.pop_front()), 64'(a & 32'hFFFF_FFFC));
                    check("rd_mem_we", 64'(q_we.pop_front()), 64'(0));
                    void'(q_wdata.pop_front());
                    void'(q_wstrb.pop_front());
                end
            end
            exp_data = oor ? 32'h0 : mem[a[11:2]];
            check("rd_data", 64'(s_rdata), 64'(exp_data));
            check("rd_resp", 64'(s_rresp), 64'(err ? 2 : 0));
            check("rd_last", 64'(s_rlast), 64'(i == len));
            if (i < len) begin
                incre_counter = 1'b1;
                @(negedge clk);
                incre_counter = 1'b0;
            end else begin
                for (int h = 0; h < hold; h++) begin
                    incre_counter = 1'(h % 2);
                    @(negedge clk);
                    check("rd_hold_fetched", 64'(data_fetched), 64'(1));
                    check("rd_hold_data", 64'(s_rdata), 64'(exp_data));
                end
                incre_counter = 1'b0;
                m_rready = 1'b1;
                @(negedge clk);
                m_rready = 1'b0;
                check("rd_idle_fetched", 64'(data_fetched), 64'(0));
                check("rd_idle_req", 64'(mem_req), 64'(0));
            end
        end
        check("rd_no_extra_req", 64'(q_addr.size()), 64'(0));
        clear_queues();
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input int size, input int burst,
                            input int bad_last, input int strb);
        logic [31:0] a, wd;
        logic [3:0]  ws;
        bit err, oor, wl;
        err = cfg_err(len, size, burst);
        m_awaddr = addr; m_awlen = 8'(len); m_awsize = 3'(size); m_awburst = 2'(burst);
        m_awvalid = 1'b1; s_awready = 1'b1;
        @(negedge clk);
        m_awvalid = 1'b0; s_awready = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a   = beat_addr(addr, len, size, burst, i);
            oor = a >= 32'(MEM_BYTES);
            wd  = $urandom;
            ws  = (strb < 0) ? 4'($urandom_range(15, 0)) : 4'(strb);
            wl  = (bad_last < 0) ? (i == len) : (i == bad_last);
            err = err | oor | (wl != (i == len));
            m_wdata = wd; m_wstrb = ws; m_wlast = wl; store_data = 1'b1;
            @(negedge clk);
            store_data = 1'b0; m_wlast = 1'b0; m_wdata = $urandom; m_wstrb = 4'($urandom_range(15, 0));
            for (int w = 0; w < 64 && !data_stored; w++) @(negedge clk);
            check("wr_stored", 64'(data_stored), 64'(1));
            check("wr_wlast_done", 64'(wlast_done), 64'(i == len));
            check("wr_bresp", 64'(s_bresp), 64'(err ? 2 : 0));
            if (oor) begin
                check("wr_oor_noreq", 64'(q_addr.size()), 64'(0));
            end else begin
                check("wr_req_count", 64'(q_addr.size()), 64'(1));
                if (q_addr.size() > 0) begin
                    check("wr_mem_addr", 64'(q_addr.pop_front()), 64'(a & 32'hFFFF_FFFC));
                    check("wr_mem_we", 64'(q_we.pop_front()), 64'(1));
                    check("wr_mem_wdata", 64'(q_wdata.pop_front()), 64'(wd));
                    check("wr_mem_wstrb", 64'(q_wstrb.pop_front()), 64'(ws));
                end
            end
            if (i < len) begin
                incre_counter = 1'b1;
                @(negedge clk);
                incre_counter = 1'b0;
            end else begin
                m_bready = 1'b1;
                @(negedge clk);
                m_bready = 1'b0;
                check("wr_idle_stored", 64'(data_stored), 64'(0));
                check("wr_idle_bresp", 64'(s_bresp), 64'(0));
            end
        end
        check("wr_no_extra_req", 64'(q_addr.size()), 64'(0));
        clear_queues();
    endtask

    initial begin
        int rw, addr, len, size, burst, bad;
        reset = 1'b1;
        m_arvalid = 0; s_arready = 0; m_araddr = 0; m_arlen = 0; m_arsize = 0; m_arburst = 0;
        m_awvalid = 0; s_awready = 0; m_awaddr = 0; m_awlen = 0; m_awsize = 0; m_awburst = 0;
        m_wdata = 0; m_wstrb = 0; m_wlast = 0; m_rready = 0; m_bready = 0;
        incre_counter = 0; store_data = 0;
        for (int k = 0; k < 1024; k++) mem[k] = $urandom;
        repeat (3) @(negedge clk);
        check("rst_fetched", 64'(data_fetched), 64'(0));
        check("rst_rlast", 64'(s_rlast), 64'(0));
        check("rst_rdata", 64'(s_rdata), 64'(0));
        check("rst_stored", 64'(data_stored), 64'(0));
        check("rst_bresp", 64'(s_bresp), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        do_read(32'h10, 3, 2, 1, 0, 1'b0);
        do_read(32'h38, 3, 2, 2, 0, 1'b0);
        do_read(32'h38, 2, 2, 2, 0, 1'b0);
        do_write(32'h40, 1, 2, 0, -1, 15);
        do_write(32'h100, 2, 2, 1, 1, -1);
        do_write(32'(MEM_BYTES - 4), 1, 2, 1, -1, -1);
        do_read(32'h200, 1, 2, 1, 5, 1'b1);

        // AW that collided with AR must have been dropped: store_data in IDLE does nothing
        store_data = 1'b1;
        @(negedge clk);
        store_data = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("aw_ignored_req", 64'(mem_req), 64'(0));
            check("aw_ignored_stored", 64'(data_stored), 64'(0));
        end

        // Reset while a write request is outstanding
        resp_en = 1'b0;
        m_awaddr = 32'h80; m_awlen = 8'd3; m_awsize = 3'd2; m_awburst = 2'd1;
        m_awvalid = 1'b1; s_awready = 1'b1;
        @(negedge clk);
        m_awvalid = 1'b0; s_awready = 1'b0;
        m_wdata = 32'hA5A5_0001; m_wstrb = 4'hF; store_data = 1'b1;
        @(negedge clk);
        store_data = 1'b0;
        for (int w = 0; w < 8 && !mem_req; w++) @(negedge clk);
        check("abort_req_pending", 64'(mem_req), 64'(1));
        check("abort_req_we", 64'(mem_we), 64'(1));
        check("abort_wdata", 64'(mem_wdata), 64'(32'hA5A5_0001));
        repeat (2) @(negedge clk);
        check("abort_req_held", 64'(mem_req), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check("abort_req_drop", 64'(mem_req), 64'(0));
        check("abort_we_drop", 64'(mem_we), 64'(0));
        check("abort_stored", 64'(data_stored), 64'(0));
        check("abort_wdata_clr", 64'(mem_wdata), 64'(0));
        reset = 1'b0;
        resp_en = 1'b1;
        clear_queues();
        @(negedge clk);
        check("abort_idle_req", 64'(mem_req), 64'(0));
        do_read(32'h84, 1, 2, 1, 0, 1'b0);

        ack_max = 2;
        for (int t = 0; t < 24; t++) begin
            rw    = int'($urandom_range(1, 0));
            addr  = int'($urandom_range(4200, 0));
            len   = ($urandom_range(4, 0) == 0) ? 15 : int'($urandom_range(7, 0));
            size  = ($urandom_range(7, 0) == 0) ? 3 : int'($urandom_range(2, 0));
            burst = int'($urandom_range(2, 0));
            bad   = ($urandom_range(5, 0) == 0) ? int'($urandom_range(32'(len), 0)) : -1;
            if (rw == 0) do_read(32'(addr), len, size, burst, int'($urandom_range(2, 0)), 1'b0);
            else         do_write(32'(addr), len, size, burst, bad, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
